// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the parametrised UART receiver:
//   - rx_state_t : receiver FSM state encoding
//   - PAR_*      : parity-mode selector values for the PARITY parameter
//   - cnt_width  : minimum register width able to hold 0..n-1 (at least 1)
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Show-ahead FIFO for received characters. The head entry is presented
//   combinationally from the storage array, so a push into an empty FIFO is
//   visible the following cycle. The head reads as zero while empty.
// Ports:
//   i_Clock    system clock
//   i_Rst_n    asynchronous active-low clear (pointers and count)
//   push       write push_data (dropped when full unless pop also occurs)
//   push_data  entry to write
//   pop        remove head entry (ignored when empty)
//   head       current head entry
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   count      current occupancy
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     i_Clock,
   input  logic                     i_Rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW   = cnt_width(DEPTH);
   localparam int CNTW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CNTW-1:0]  count_reg;
   logic             do_push, do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNTW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge i_Clock) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNTW'(1);
            2'b01:   count_reg <= count_reg - CNTW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = empty ? '0 : mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/uart_rx_fifo_gen.sv
// uart_rx_fifo_gen
//   Parametrised UART receiver (DATA_BITS data, optional odd/even parity,
//   1 or 2 stop bits) with a show-ahead character FIFO drained by a
//   valid/ready handshake. The receiver never stalls on the consumer.
// Ports:
//   i_Clock       system clock
//   i_Rst_n       asynchronous active-low reset
//   i_Rx_Serial   serial line, idle high (asynchronous)
//   i_Rx_Ready    consumer accepts head entry when high with o_Rx_DV
//   o_Rx_DV       FIFO non-empty
//   o_Rx_Byte     head entry data
//   o_Frame_Err   head entry had a low stop sample
//   o_Parity_Err  head entry failed parity
//   o_Overrun     one-cycle pulse: completed character dropped, FIFO full
//   o_Fifo_Count  current FIFO occupancy
module uart_rx_fifo_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_n,
   input  logic                          i_Rx_Serial,
   input  logic                          i_Rx_Ready,
   output logic                          o_Rx_DV,
   output logic [DATA_BITS-1:0]          o_Rx_Byte,
   output logic                          o_Frame_Err,
   output logic                          o_Parity_Err,
   output logic                          o_Overrun,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int IW = cnt_width(DATA_BITS);
   localparam int FW = DATA_BITS + 2;
   localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   logic rx_meta_reg, rx_sync;

   rx_state_t              state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic [IW-1:0]          idx_reg, idx_next;
   logic [DATA_BITS-1:0]   data_reg, data_next;
   logic                   perr_reg, perr_next;
   logic                   ferr_reg, ferr_next;
   logic                   stop2_reg, stop2_next;   // first of two stop bits taken
   logic                   bit_done, frame_now;

   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]          fifo_push_data, fifo_head;
   logic                   overrun_reg;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta_reg <= 1'b1;
         rx_sync     <= 1'b1;
      end else begin
         rx_meta_reg <= i_Rx_Serial;
         rx_sync     <= rx_meta_reg;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         data_reg  <= '0;
         perr_reg  <= 1'b0;
         ferr_reg  <= 1'b0;
         stop2_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         data_reg  <= data_next;
         perr_reg  <= perr_next;
         ferr_reg  <= ferr_next;
         stop2_reg <= stop2_next;
      end
   end

   assign bit_done  = (cnt_reg == LAST);
   // Frame status including the stop sample being taken this cycle.
   assign frame_now = ferr_reg | ~rx_sync;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      data_next  = data_reg;
      perr_next  = perr_reg;
      ferr_next  = ferr_reg;
      stop2_next = stop2_reg;
      fifo_push  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            cnt_next   = '0;
            idx_next   = '0;
            perr_next  = 1'b0;
            ferr_next  = 1'b0;
            stop2_next = 1'b0;
            if (!rx_sync)
               state_next = S_START;
         end
         S_START: begin
            // Re-check the line mid-way through the start bit.
            if (cnt_reg == HALF) begin
               if (!rx_sync) begin
                  cnt_next   = '0;
                  state_next = S_DATA;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_DATA: begin
            if (!bit_done) begin
               cnt_next = cnt_reg + CW'(1);
            end else begin
               cnt_next           = '0;
               data_next[idx_reg] = rx_sync;
               if (idx_reg == LAST_IDX) begin
                  idx_next   = '0;
                  state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  idx_next = idx_reg + IW'(1);
               end
            end
         end
         S_PARITY: begin
            if (!bit_done) begin
               cnt_next = cnt_reg + CW'(1);
            end else begin
               cnt_next   = '0;
               perr_next  = (PARITY == PAR_ODD) ? ~(^{data_reg, rx_sync})
                                                :  (^{data_reg, rx_sync});
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (!bit_done) begin
               cnt_next = cnt_reg + CW'(1);
            end else begin
               cnt_next = '0;
               if ((STOP_BITS == 2) && !stop2_reg) begin
                  stop2_next = 1'b1;
                  ferr_next  = frame_now;
               end else begin
                  fifo_push  = 1'b1;
                  ferr_next  = frame_now;
                  state_next = frame_now ? S_WAIT_HIGH : S_IDLE;
               end
            end
         end
         S_WAIT_HIGH: begin
            // Hold off while a break keeps the line low.
            if (rx_sync)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign fifo_push_data = {perr_reg, frame_now, data_reg};
   assign fifo_pop       = i_Rx_Ready && !fifo_empty;

   uart_rx_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Rst_n   (i_Rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_Fifo_Count)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n)
         overrun_reg <= 1'b0;
      else
         overrun_reg <= fifo_push && fifo_full && !fifo_pop;
   end

   assign o_Rx_DV      = !fifo_empty;
   assign o_Rx_Byte    = fifo_head[DATA_BITS-1:0];
   assign o_Frame_Err  = fifo_head[DATA_BITS];
   assign o_Parity_Err = fifo_head[DATA_BITS+1];
   assign o_Overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
module tb_uart_rx_fifo_gen;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx0 = 1'b1, rx1 = 1'b1;
   logic       rdy0 = 1'b0, rdy1 = 1'b0;
   logic       dv0, fe0, pe0, ov0;
   logic       dv1, fe1, pe1, ov1;
   logic [7:0] byte0, byte1;
   logic [2:0] cnt0;
   logic [1:0] cnt1;

   int checks = 0;
   int errors = 0;
   int ovr_cnt = 0;

   always #5 clk = ~clk;

   // 8N1, depth 4
   uart_rx_fifo_gen #(
      .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0),
      .STOP_BITS (1), .FIFO_DEPTH (4)
   ) dut0 (
      .i_Clock (clk), .i_Rst_n (rst_n), .i_Rx_Serial (rx0), .i_Rx_Ready (rdy0),
      .o_Rx_DV (dv0), .o_Rx_Byte (byte0), .o_Frame_Err (fe0),
      .o_Parity_Err (pe0), .o_Overrun (ov0), .o_Fifo_Count (cnt0)
   );

   // 8E2, depth 2
   uart_rx_fifo_gen #(
      .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (2),
      .STOP_BITS (2), .FIFO_DEPTH (2)
   ) dut1 (
      .i_Clock (clk), .i_Rst_n (rst_n), .i_Rx_Serial (rx1), .i_Rx_Ready (rdy1),
      .o_Rx_DV (dv1), .o_Rx_Byte (byte1), .o_Frame_Err (fe1),
      .o_Parity_Err (pe1), .o_Overrun (ov1), .o_Fifo_Count (cnt1)
   );

   always @(negedge clk) begin
      if (ov0 === 1'b1)
         ovr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rx0 = v;
      else          rx1 = v;
   endtask

   task automatic wait_bit();
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                             input logic pbit, input logic s1, input logic s2,
                             input int nstop);
      $display("rx%0d frame data=0x%02h par=%0d/%0b stop=%0b%0b", sel, d, use_par, pbit, s1, s2);
      @(negedge clk);
      set_line(sel, 1'b0);
      wait_bit();
      for (int i = 0; i < 8; i++) begin
         set_line(sel, d[i]);
         wait_bit();
      end
      if (use_par) begin
         set_line(sel, pbit);
         wait_bit();
      end
      set_line(sel, s1);
      wait_bit();
      if (nstop == 2) begin
         set_line(sel, s2);
         wait_bit();
      end
      set_line(sel, 1'b1);
   endtask

   task automatic send8(input logic [7:0] d);
      send_frame(0, d, 1'b0, 1'b0, 1'b1, 1'b1, 1);
   endtask

   task automatic pop0();
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
   endtask

   task automatic pop1();
      rdy1 = 1'b1;
      @(negedge clk);
      rdy1 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", dv0); end
      checks++; if (byte0 !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", byte0); end
      checks++; if ({fe0, pe0, ov0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {fe0, pe0, ov0}); end
      checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
      checks++; if ({dv1, cnt1} !== 3'b000) begin errors++; $display("FAIL reset_dut1: got %b expected 000", {dv1, cnt1}); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      send8(8'hA5);
      @(negedge clk);
      checks++; if (dv0 !== 1'b1) begin errors++; $display("FAIL basic_dv: got %b expected 1", dv0); end
      checks++; if (byte0 !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %h expected a5", byte0); end
      checks++; if ({fe0, pe0} !== 2'b00) begin errors++; $display("FAIL basic_errs: got %b expected 00", {fe0, pe0}); end
      checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", cnt0); end
      pop0();
      checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL basic_pop_dv: got %b expected 0", dv0); end
      checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL basic_pop_count: got %0d expected 0", cnt0); end
   endtask

   task automatic test_parity();
      // 0x03 has two ones: even parity bit should be 0
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 2);
      @(negedge clk);
      checks++; if (dv1 !== 1'b1) begin errors++; $display("FAIL par_bad_dv: got %b expected 1", dv1); end
      checks++; if (byte1 !== 8'h03) begin errors++; $display("FAIL par_bad_byte: got %h expected 03", byte1); end
      checks++; if ({pe1, fe1} !== 2'b10) begin errors++; $display("FAIL par_bad_flags: got pe/fe %b expected 10", {pe1, fe1}); end
      pop1();
      send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 2);
      @(negedge clk);
      checks++; if (byte1 !== 8'h03) begin errors++; $display("FAIL par_ok_byte: got %h expected 03", byte1); end
      checks++; if ({dv1, pe1, fe1} !== 3'b100) begin errors++; $display("FAIL par_ok_flags: got dv/pe/fe %b expected 100", {dv1, pe1, fe1}); end
      pop1();
      // 0xC4 has three ones: parity bit 1 is correct; second stop bit low
      send_frame(1, 8'hC4, 1'b1, 1'b1, 1'b1, 1'b0, 2);
      @(negedge clk);
      checks++; if (byte1 !== 8'hC4) begin errors++; $display("FAIL stop2_byte: got %h expected c4", byte1); end
      checks++; if ({dv1, pe1, fe1} !== 3'b101) begin errors++; $display("FAIL stop2_flags: got dv/pe/fe %b expected 101", {dv1, pe1, fe1}); end
      pop1();
      checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL par_drain_count: got %0d expected 0", cnt1); end
   endtask

   task automatic test_break();
      $display("rx0 break: line low for 20 bit times");
      @(negedge clk);
      rx0 = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL break_count: got %0d expected 1", cnt0); end
      checks++; if (byte0 !== 8'h00) begin errors++; $display("FAIL break_byte: got %h expected 00", byte0); end
      checks++; if ({fe0, pe0} !== 2'b10) begin errors++; $display("FAIL break_flags: got fe/pe %b expected 10", {fe0, pe0}); end
      rx0 = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL break_release_count: got %0d expected 1", cnt0); end
      pop0();
      send8(8'h3C);
      @(negedge clk);
      checks++; if ({dv0, fe0, byte0} !== {2'b10, 8'h3C}) begin errors++; $display("FAIL break_after: got dv/fe/byte %b %b %h expected 1 0 3c", dv0, fe0, byte0); end
      pop0();
   endtask

   task automatic test_overrun();
      int base;
      logic [7:0] exp;
      base = ovr_cnt;
      for (int i = 0; i < 4; i++) begin
         exp = 8'((i + 1) * 17);
         send8(exp);
      end
      @(negedge clk);
      checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL ovr_fill_count: got %0d expected 4", cnt0); end
      checks++; if (ovr_cnt - base !== 0) begin errors++; $display("FAIL ovr_fill_pulses: got %0d expected 0", ovr_cnt - base); end
      send8(8'h55);
      repeat (2) @(negedge clk);
      checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", cnt0); end
      checks++; if (ovr_cnt - base !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - base); end
      for (int i = 0; i < 4; i++) begin
         exp = 8'((i + 1) * 17);
         checks++; if ({dv0, byte0} !== {1'b1, exp}) begin errors++; $display("FAIL ovr_drain%0d: got dv/byte %b %h expected 1 %h", i, dv0, byte0, exp); end
         pop0();
      end
      checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b expected 0", dv0); end
   endtask

   task automatic test_full_push_pop();
      int base;
      logic [7:0] exp [4];
      exp[0] = 8'h62; exp[1] = 8'h63; exp[2] = 8'h64; exp[3] = 8'h55;
      base = ovr_cnt;
      for (int i = 0; i < 4; i++)
         send8(8'(8'h61 + i));
      // Final stop sample lands on the 79th rising edge after the start bit.
      fork
         send8(8'h55);
         begin
            repeat (79) @(negedge clk);
            rdy0 = 1'b1;
            @(negedge clk);
            rdy0 = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL pp_count: got %0d expected 4", cnt0); end
      checks++; if (ovr_cnt - base !== 0) begin errors++; $display("FAIL pp_pulses: got %0d expected 0", ovr_cnt - base); end
      for (int i = 0; i < 4; i++) begin
         checks++; if ({dv0, byte0} !== {1'b1, exp[i]}) begin errors++; $display("FAIL pp_drain%0d: got dv/byte %b %h expected 1 %h", i, dv0, byte0, exp[i]); end
         pop0();
      end
   endtask

   task automatic test_glitch();
      $display("rx0 glitch: 2-cycle low pulse");
      @(negedge clk);
      rx0 = 1'b0;
      repeat (2) @(negedge clk);
      rx0 = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++; if ({dv0, cnt0} !== 4'b0000) begin errors++; $display("FAIL glitch: got dv/count %b %0d expected 0 0", dv0, cnt0); end
   endtask

   task automatic test_reset_mid();
      send8(8'h99);
      @(negedge clk);
      checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 1", cnt0); end
      fork
         send8(8'h77);
         begin
            repeat (30) @(negedge clk);
            rst_n = 1'b0;
            #1;
            checks++; if ({dv0, cnt0, byte0} !== 12'h000) begin errors++; $display("FAIL rstmid_outputs: got dv/count/byte %b %0d %h expected 0 0 00", dv0, cnt0, byte0); end
         end
      join
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL rstmid_no_push: got %0d expected 0", cnt0); end
      send8(8'h5A);
      @(negedge clk);
      checks++; if ({dv0, fe0, pe0, byte0} !== {3'b100, 8'h5A}) begin errors++; $display("FAIL rstmid_after: got dv/fe/pe/byte %b%b%b %h expected 100 5a", dv0, fe0, pe0, byte0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_overrun();
      test_full_push_pop();
      test_glitch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo_gen.md
Name: uart_rx_fifo_gen

Overview:
Parametrised UART receiver, successor to the single-byte 8N1 receiver. It supports configurable data width, parity mode and stop-bit count, and reports framing and parity errors per character. Received characters are buffered in an internal show-ahead FIFO drained by a valid/ready handshake, replacing the old wait-for-next stall. It sits between the board RX pin and the terminal/CPU consumer on the memory clock.

Parameters:
CLKS_PER_BIT, 217, i_Clock cycles per bit (legal range ≥ 4).
DATA_BITS, 8, data bits per character (legal range 5..9), LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, buffered characters (power of 2, ≥ 2).

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_Serial  in  1  asynchronous serial line, idle high
i_Rx_Ready  in  1  consumer accepts head entry when high together with o_Rx_DV
o_Rx_DV  out  1  FIFO non-empty; head entry valid
o_Rx_Byte  out  DATA_BITS  head entry data
o_Frame_Err  out  1  head entry had a stop bit sampled low
o_Parity_Err  out  1  head entry parity mismatch (always 0 when PARITY = 0)
o_Overrun  out  1  one-cycle pulse: completed character dropped because FIFO full
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, while i_Rst_n = 0):
  - Synchroniser flops = 1; FSM = IDLE; counters = 0; FIFO empty.
  - All outputs 0; o_Fifo_Count = 0.
  - Reset mid-frame discards the partial character; no push.
- Input path: 2-flop synchroniser; the FSM uses only the synchronised line.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: clock counter and bit index cleared. Synchronised line = 0 -> START.
  - START: count to (CLKS_PER_BIT-1)/2. Line still 0 -> clear counter, go to DATA. Line 1 -> IDLE (glitch rejected, nothing pushed).
  - DATA: sample every CLKS_PER_BIT cycles into shift register bit [index], LSB first. After bit DATA_BITS-1 -> PARITY if PARITY ≠ 0, else STOP.
  - PARITY: sample after CLKS_PER_BIT. Error if XOR(data, parity bit) ≠ 1 for odd, or ≠ 0 for even.
  - STOP: sample after CLKS_PER_BIT. Any low stop sample sets the frame error. When STOP_BITS = 2, sample a second time after a further CLKS_PER_BIT.
  - On the final stop sample:
    - push {parity_err, frame_err, data} in the same cycle;
    - go to IDLE if the frame was OK, else WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line = 1, then IDLE. This stops a break condition re-triggering.
- FIFO:
  - Show-ahead: head appears on outputs the cycle after the push into an empty FIFO.
  - Pop when o_Rx_DV && i_Rx_Ready; the next entry is visible the following cycle.
  - Full and push without pop: character dropped, o_Overrun pulses 1 cycle, contents unchanged.
  - Full with simultaneous push and pop: both occur, no overrun, count unchanged.
  - Empty with pop request: ignored.
  - Pointers wrap modulo FIFO_DEPTH; count saturates correctly at both ends.
- No stall: the receiver always returns to IDLE regardless of consumer state.

Decomposition:
- Package uart_pkg:
  - FSM state encodings;
  - parity-mode constants PAR_NONE / PAR_ODD / PAR_EVEN;
  - $clog2-based width function for the counter and FIFO pointers.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO, width DATA_BITS+2, depth FIFO_DEPTH, with push/pop/full/empty/count and i_Rst_n async clear.
- The top-level file holds the synchroniser, FSM and shift/parity logic.

Test Plan:
- Basic 8N1: CLKS_PER_BIT = 8, send 0xA5, i_Rx_Ready = 0 -> o_Rx_DV = 1, o_Rx_Byte = 0xA5, both error flags 0, count = 1. Then assert Ready for 1 cycle -> DV = 0 next cycle.
- Even parity (PARITY = 2): send 0x03 with parity bit 1 -> o_Parity_Err = 1, byte = 0x03. Send 0x03 with parity bit 0 -> Parity_Err = 0.
- Framing and break: hold the line low for 20 bit times -> one entry, byte 0x00, o_Frame_Err = 1. No further push until the line returns high and a new start bit arrives.
- Overrun: FIFO_DEPTH = 4, send 5 characters 0x11..0x55 with Ready = 0 -> count = 4. o_Overrun pulses once at the 5th stop sample. Draining yields 0x11, 0x22, 0x33, 0x44.
- Simultaneous push/pop at full: Ready held high during the 5th character's final stop sample -> no overrun, count stays 4, 0x55 is the last entry.
- Glitch and reset: a 2-cycle low pulse produces no entry. Asserting i_Rst_n = 0 mid-DATA empties the FIFO and clears outputs; a subsequent 0x5A is received correctly.
